dcache_wb_direct: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache in the MEM stage.
- Serves core loads and stores and returns the raw aligned 32-bit word, which the downstream load-extension stage consumes.
- On a miss it raises `miss` to stall the pipeline, writes back the dirty victim line word by word, then refills the line from main memory.

---
 rtl/dcache_wb_direct.sv | 208 ++++++++++++++++++++
 tb/tb_dcache_wb_direct.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_direct.sv
// dcache_wb_direct: direct-mapped, write-back, write-allocate data cache
// for the MEM stage. A miss stalls the core, writes the dirty victim back
// word by word, then refills the line from main memory.
// Optional build macro DCACHE_PERF_EN adds hit_cnt/miss_cnt counters.
//
// Handshake: a core request (rd_req/wr_req) is held with addr, wr_data and
// wr_be stable until a cycle where miss is low; that cycle completes it.
// Towards memory, mem_wr_req/mem_rd_req are held with a stable mem_addr and
// a beat completes in a cycle where mem_wready (writeback) or mem_rvalid
// (refill) is high; the two requests are never high together.
module dcache_wb_direct #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 4,
    parameter int TAG_ADDR_LEN  = 30 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic [31:0] rd_data,
    output logic        miss,
`ifdef DCACHE_PERF_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    output logic [1:0]  dbg_state,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic        mem_wready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rd_data
);

    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
    localparam int SET_SIZE  = 1 << SET_ADDR_LEN;
    localparam logic [LINE_ADDR_LEN-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWAP_OUT   = 2'd1,
        SWAP_IN    = 2'd2,
        SWAP_IN_OK = 2'd3
    } state_t;

    state_t                     state, state_nxt;
    logic [LINE_ADDR_LEN-1:0]   cnt, cnt_nxt;
    logic [TAG_ADDR_LEN-1:0]    xfer_tag, xfer_tag_nxt;

    logic [31:0]                data_array [SET_SIZE][LINE_SIZE];
    logic [TAG_ADDR_LEN-1:0]    tag_array  [SET_SIZE];
    logic [SET_SIZE-1:0]        valid, dirty;

    logic [TAG_ADDR_LEN-1:0]    req_tag;
    logic [SET_ADDR_LEN-1:0]    req_set;
    logic [LINE_ADDR_LEN-1:0]   req_off;
    logic                       req, hit, idle_hit, store_hit;
    logic                       fill_we, line_done;
    logic                       unused_addr_bits;

    assign req_off  = addr[2 +: LINE_ADDR_LEN];
    assign req_set  = addr[LINE_ADDR_LEN + 2 +: SET_ADDR_LEN];
    assign req_tag  = addr[31 -: TAG_ADDR_LEN];
    // Byte lane bits are not part of the word address.
    assign unused_addr_bits = ^addr[1:0];

    assign req       = rd_req | wr_req;
    assign hit       = valid[req_set] && (tag_array[req_set] == req_tag);
    assign idle_hit  = (state == IDLE) && hit;
    assign store_hit = idle_hit && wr_req;
    assign miss      = req & ~idle_hit;
    assign rd_data   = idle_hit ? data_array[req_set][req_off] : 32'd0;
    assign dbg_state = state;

    // Next-state, transfer counter and memory-side outputs.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        xfer_tag_nxt = xfer_tag;
        mem_rd_req   = 1'b0;
        mem_wr_req   = 1'b0;
        mem_addr     = 32'd0;
        mem_wr_data  = 32'd0;
        fill_we      = 1'b0;
        line_done    = 1'b0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    cnt_nxt = '0;
                    if (valid[req_set] && dirty[req_set]) begin
                        xfer_tag_nxt = tag_array[req_set];
                        state_nxt    = SWAP_OUT;
                    end else begin
                        xfer_tag_nxt = req_tag;
                        state_nxt    = SWAP_IN;
                    end
                end
            end
            SWAP_OUT: begin
                mem_wr_req  = 1'b1;
                mem_addr    = {xfer_tag, req_set, cnt, 2'b00};
                mem_wr_data = data_array[req_set][cnt];
                if (mem_wready) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // The victim is out; the refill uses the request tag.
                        xfer_tag_nxt = req_tag;
                        state_nxt    = SWAP_IN;
                    end
                end
            end
            SWAP_IN: begin
                mem_rd_req = 1'b1;
                mem_addr   = {xfer_tag, req_set, cnt, 2'b00};
                if (mem_rvalid) begin
                    fill_we = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = SWAP_IN_OK;
                    end
                end
            end
            SWAP_IN_OK: begin
                line_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, beat counter and transfer tag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            xfer_tag <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            xfer_tag <= xfer_tag_nxt;
        end
    end

    // Valid/dirty bits: cleared on reset, set on refill completion or store hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (line_done) begin
            valid[req_set] <= 1'b1;
            dirty[req_set] <= 1'b0;
        end else if (store_hit) begin
            dirty[req_set] <= 1'b1;
        end
    end

    // Tag array: written only when a refilled line becomes valid.
    always_ff @(posedge clk) begin
        if (!rst && line_done) begin
            tag_array[req_set] <= xfer_tag;
        end
    end

    // Data array: refill beats and byte-enabled store hits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_we) begin
                data_array[req_set][cnt] <= mem_rd_data;
            end else if (store_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) begin
                        data_array[req_set][req_off][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef DCACHE_PERF_EN
    logic was_miss;

    // Performance counters: hits without a preceding miss, and miss starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
            was_miss <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt != IDLE) begin
                miss_cnt <= miss_cnt + 32'd1;
                was_miss <= 1'b1;
            end else if (idle_hit && req) begin
                if (!was_miss) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end
                was_miss <= 1'b0;
            end
        end
    end
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_dcache_wb_direct.sv
// tb_dcache_wb_direct: randomized bench for dcache_wb_direct. The model is
// a flat view of memory as the core should see it (gold), the backing
// memory contents, and which tag each set holds and whether it was stored to.
module tb_dcache_wb_direct;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        rd_req, wr_req;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [31:0] rd_data;
    logic        miss;
    logic [1:0]  dbg_state;
    logic        mem_rd_req, mem_wr_req;
    logic [31:0] mem_addr, mem_wr_data;
    logic        mem_wready, mem_rvalid;
    logic [31:0] mem_rd_data;
`ifdef DCACHE_PERF_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    dcache_wb_direct dut (
        .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
        .wr_data(wr_data), .wr_be(wr_be), .rd_data(rd_data), .miss(miss),
`ifdef DCACHE_PERF_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .dbg_state(dbg_state),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_wready(mem_wready),
        .mem_rvalid(mem_rvalid), .mem_rd_data(mem_rd_data)
    );

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    logic [31:0] backing [int unsigned];
    logic [31:0] gold    [int unsigned];
    bit          m_valid [16];
    bit          m_dirty [16];
    logic [22:0] m_tag   [16];
    int          exp_hits = 0, exp_misses = 0;

    int rvalid_pct = 100, wready_pct = 100;
    int stall_beat = -1, stall_len = 0, rst_beat = -1;
    logic [31:0] rdv;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned wa);
        return 32'h1000 + wa - 32'h10;
    endfunction

    function automatic logic [31:0] backing_rd(input int unsigned wa);
        return backing.exists(wa) ? backing[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] gold_rd(input int unsigned wa);
        return gold.exists(wa) ? gold[wa] : init_word(wa);
    endfunction

    // Losing the cache contents makes memory the only truth again.
    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        gold.delete();
        foreach (backing[k]) gold[k] = backing[k];
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // ---------------- driver + memory responder ----------------
    task automatic do_access(input logic [31:0] a, input bit rd, input bit wr,
                             input logic [31:0] wd, input logic [3:0] be,
                             output logic [31:0] rv);
        int unsigned wa = {2'b00, a[31:2]};
        logic [3:0]  set = a[8:5];
        logic [22:0] tag = a[31:9];
        bit exp_miss = !(m_valid[set] && m_tag[set] == tag);
        bit exp_wb   = exp_miss && m_valid[set] && m_dirty[set];
        logic [22:0] vtag = m_tag[set];
        int wb_n = 0, rf_n = 0, stall_left = 0, cyc = 0, xfer_cyc = 0;
        bit done = 1'b0, aborted = 1'b0, give;
        logic [31:0] ea;
        rv = 32'd0;
        @(negedge clk);
        addr = a; rd_req = rd; wr_req = wr; wr_data = wd; wr_be = be;
        mem_wready = 1'b0; mem_rvalid = 1'b0;
        #1;
        check("miss_first", {31'd0, miss}, {31'd0, exp_miss});
        while (!done && cyc < 400) begin
            if (!miss) begin
                rv = rd_data;
                if (rd) check("rd_data", rd_data, gold_rd(wa));
                done = 1'b1;
            end else begin
                check("req_excl", {31'd0, mem_rd_req & mem_wr_req}, 32'd0);
                if (mem_wr_req) begin
                    xfer_cyc++;
                    check("wb_expected", {31'd0, exp_wb}, 32'd1);
                    ea = {vtag, set, wb_n[2:0], 2'b00};
                    check("wb_addr", mem_addr, ea);
                    check("wb_data", mem_wr_data, gold_rd({2'b00, ea[31:2]}));
                    if ($urandom_range(99) < wready_pct) begin
                        mem_wready = 1'b1;
                        backing[{2'b00, ea[31:2]}] = mem_wr_data;
                        wb_n++;
                    end
                end else if (mem_rd_req) begin
                    xfer_cyc++;
                    check("rf_order", wb_n, exp_wb ? 8 : 0);
                    ea = {tag, set, rf_n[2:0], 2'b00};
                    check("rf_addr", mem_addr, ea);
                    if (rst_beat == rf_n) begin
                        rst = 1'b1;
                        @(negedge clk); #1;
                        check("rst_rd_req", {31'd0, mem_rd_req}, 32'd0);
                        check("rst_wr_req", {31'd0, mem_wr_req}, 32'd0);
                        check("rst_miss", {31'd0, miss}, 32'd1);
                        rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
                        rst_beat = -1;
                        model_reset();
                        aborted = 1'b1;
                        done = 1'b1;
                    end else begin
                        give = ($urandom_range(99) < rvalid_pct);
                        if (stall_beat == rf_n && stall_left < stall_len) begin
                            give = 1'b0;
                            stall_left++;
                        end
                        if (give) begin
                            mem_rvalid  = 1'b1;
                            mem_rd_data = backing_rd({2'b00, ea[31:2]});
                            rf_n++;
                        end
                    end
                end
            end
            if (!done) begin
                @(negedge clk);
                mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rd_data = $urandom;
                #1;
                cyc++;
            end
        end
        if (!done) begin
            check("timeout", 32'd0, 32'd1);
            $display("FAIL timeout: access to %h never completed", a);
        end else if (!aborted) begin
            check("wb_beats", wb_n, exp_wb ? 8 : 0);
            check("rf_beats", rf_n, exp_miss ? 8 : 0);
            check("latency", cyc, exp_miss ? xfer_cyc + 2 : 0);
            if (wr) begin
                logic [31:0] g = gold_rd(wa);
                for (int b = 0; b < 4; b++)
                    if (be[b]) g[8*b +: 8] = wd[8*b +: 8];
                gold[wa] = g;
            end
            m_valid[set] = 1'b1;
            m_tag[set]   = tag;
            m_dirty[set] = (exp_miss ? 1'b0 : m_dirty[set]) | wr;
            if (exp_miss) exp_misses++; else exp_hits++;
            @(negedge clk);
            rd_req = 1'b0; wr_req = 1'b0;
            #1;
            check("idle_miss", {31'd0, miss}, 32'd0);
        end
        mem_wready = 1'b0; mem_rvalid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; addr = 32'd0; rd_req = 1'b0; wr_req = 1'b0;
        wr_data = 32'd0; wr_be = 4'd0;
        mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rd_data = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_miss0", {31'd0, miss}, 32'd0);
        check("rst_mem_rd_req", {31'd0, mem_rd_req}, 32'd0);
        check("rst_mem_wr_req", {31'd0, mem_wr_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wr_data", mem_wr_data, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        rst = 1'b0;

        // Directed scenarios with exact memory contents.
        exp_q = {32'h0000_1000, 32'h0000_1002, 32'h0000_AB00, 32'h0000_1080,
                 32'h0000_AB00, 32'h0000_1007, 32'h0000_AB00};
        do_access(32'h40, 1, 0, 32'd0, 4'd0, rdv);
        check("tp_refill_word0", rdv, exp_q.pop_front());
        do_access(32'h48, 1, 0, 32'd0, 4'd0, rdv);
        check("tp_hit_word2", rdv, exp_q.pop_front());
        do_access(32'h41, 0, 1, 32'h0000_AB00, 4'b0010, rdv);
        do_access(32'h40, 1, 0, 32'd0, 4'd0, rdv);
        check("tp_sb_merge", rdv, exp_q.pop_front());
        do_access(32'h240, 1, 0, 32'd0, 4'd0, rdv);
        check("tp_evict_refill", rdv, exp_q.pop_front());
        check("tp_writeback_mem", backing_rd(32'h10), 32'h0000_AB00);
        stall_beat = 3; stall_len = 5;
        do_access(32'h40, 1, 0, 32'd0, 4'd0, rdv);
        stall_beat = -1;
        check("tp_stall_refill", rdv, exp_q.pop_front());
        do_access(32'h5C, 1, 0, 32'd0, 4'd0, rdv);
        check("tp_stall_word7", rdv, exp_q.pop_front());
        rst_beat = 4;
        do_access(32'h440, 1, 0, 32'd0, 4'd0, rdv);
        do_access(32'h40, 1, 0, 32'd0, 4'd0, rdv);
        check("tp_after_rst", rdv, exp_q.pop_front());

        // Randomized traffic over a few conflicting tags and sets.
        rvalid_pct = 70; wready_pct = 70;
        for (int i = 0; i < 120; i++) begin
            logic [31:0] a;
            bit rd, wr;
            logic [3:0] be;
            a = {14'd0, 9'($urandom_range(0, 2)), 4'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            wr = ($urandom_range(0, 2) == 0);
            rd = !wr || ($urandom_range(0, 3) == 0);
            be = 4'($urandom_range(1, 15));
            do_access(a, rd, wr, $urandom, be, rdv);
        end
        rvalid_pct = 100; wready_pct = 100;
        // Read back every touched word through the cache.
        foreach (gold[k]) begin
            do_access({k[29:0], 2'b00}, 1, 0, 32'd0, 4'd0, rdv);
        end

`ifdef DCACHE_PERF_EN
        check("hit_cnt", hit_cnt, exp_hits);
        check("miss_cnt", miss_cnt, exp_misses);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
